// File: rtl/rv_test_mon_pkg.sv
// Shared types and constants for the riscv-tests completion monitor.
// Register indices follow the rv32ui-p-* convention (x26 done, x27 pass, x3 test number).
package rv_test_mon_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int DEF_DONE_REG = 26;
    localparam int DEF_PASS_REG = 27;
    localparam int DEF_TNUM_REG = 3;

    typedef enum logic [1:0] {
        CH_RUN,
        CH_DRAIN,
        CH_JUDGED
    } ch_state_t;

endpackage

// File: rtl/rv_test_mon_ch.sv
// One monitored core: register shadows, RUN/DRAIN/JUDGED FSM and drain counter.
// The *_next outputs show what the channel registers on the coming edge, so the top can stay aligned with it.
module rv_test_mon_ch
    import rv_test_mon_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DONE_REG  = DEF_DONE_REG,
    parameter int PASS_REG  = DEF_PASS_REG,
    parameter int TNUM_REG  = DEF_TNUM_REG,
    parameter int DRAIN_CYC = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] addr,
    input  logic [XLEN-1:0]      data,
    output logic                 judged_next,
    output logic                 pass_next,
    output logic [XLEN-1:0]      tnum_next
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? DW'(DRAIN_CYC - 1) : '0;
    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    ch_state_t         state_reg, state_next;
    logic [DW-1:0]     cnt_reg, cnt_next;
    logic [XLEN-1:0]   done_sh_reg, pass_sh_reg, tnum_sh_reg;
    logic [XLEN-1:0]   done_sh_next, pass_sh_next, tnum_sh_next;
    logic              verdict_pass_reg;
    logic [XLEN-1:0]   verdict_tnum_reg;
    logic              wr_ok;
    logic              entering;

    // x0 is hardwired zero in the core, so writes to it never reach a shadow.
    assign wr_ok        = we && (addr != '0);
    assign done_sh_next = (wr_ok && addr == REG_IDX_W'(DONE_REG)) ? data : done_sh_reg;
    assign pass_sh_next = (wr_ok && addr == REG_IDX_W'(PASS_REG)) ? data : pass_sh_reg;
    assign tnum_sh_next = (wr_ok && addr == REG_IDX_W'(TNUM_REG)) ? data : tnum_sh_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CH_RUN: begin
                cnt_next = '0;
                if (done_sh_next == ONE) begin
                    state_next = (DRAIN_CYC == 0) ? CH_JUDGED : CH_DRAIN;
                end
            end
            CH_DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = CH_JUDGED;
                end else begin
                    cnt_next = cnt_reg + DW'(1);
                end
            end
            CH_JUDGED: state_next = CH_JUDGED;
            default:   state_next = CH_RUN;
        endcase
    end

    assign entering    = (state_next == CH_JUDGED) && (state_reg != CH_JUDGED);
    assign judged_next = (state_next == CH_JUDGED);
    // Shadow "next" values forward a write landing on the judging edge itself.
    assign pass_next   = entering ? (pass_sh_next == ONE) : verdict_pass_reg;
    assign tnum_next   = (state_reg == CH_JUDGED) ? verdict_tnum_reg : tnum_sh_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= CH_RUN;
            cnt_reg          <= '0;
            done_sh_reg      <= '0;
            pass_sh_reg      <= '0;
            tnum_sh_reg      <= '0;
            verdict_pass_reg <= 1'b0;
            verdict_tnum_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            done_sh_reg <= done_sh_next;
            pass_sh_reg <= pass_sh_next;
            tnum_sh_reg <= tnum_sh_next;
            if (entering) begin
                verdict_pass_reg <= pass_sh_next == ONE;
                verdict_tnum_reg <= tnum_sh_next;
            end
        end
    end

endmodule

// File: rtl/rv_test_monitor.sv
// Multi-core riscv-tests completion monitor: per-core judging, global timeout, aggregate verdict, cycle count.
// Define TEST_MON_TRACE_EN for simulation-only verdict banners and per-channel judgement lines.
module rv_test_monitor
    import rv_test_mon_pkg::*;
#(
    parameter int NUM_CH    = 1,
    parameter int XLEN      = 32,
    parameter int DONE_REG  = DEF_DONE_REG,
    parameter int PASS_REG  = DEF_PASS_REG,
    parameter int TNUM_REG  = DEF_TNUM_REG,
    parameter int DRAIN_CYC = 10,
    parameter int TIMEOUT   = 100000,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           wb_we_i,
    input  logic [REG_IDX_W*NUM_CH-1:0] wb_addr_i,
    input  logic [XLEN*NUM_CH-1:0]      wb_data_i,
    output logic                        done_o,
    output logic                        pass_o,
    output logic                        fail_o,
    output logic                        timeout_o,
    output logic [NUM_CH-1:0]           ch_pass_o,
    output logic [XLEN-1:0]             fail_testnum_o,
    output logic [CNT_W-1:0]            cycles_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [NUM_CH-1:0] judged_next;
    logic [NUM_CH-1:0] pass_vec;
    logic [NUM_CH-1:0] ch_pass_next;
    logic [XLEN-1:0]   tnum_next [NUM_CH];

    logic              done_reg, pass_reg, fail_reg, timeout_reg;
    logic [NUM_CH-1:0] ch_pass_reg;
    logic [XLEN-1:0]   fail_tnum_reg;
    logic [CNT_W-1:0]  cycles_reg;

    logic              all_judged;
    logic              tmo_hit;
    logic              fire;
    logic [XLEN-1:0]   fail_tnum_sel;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            rv_test_mon_ch #(
                .XLEN      (XLEN),
                .DONE_REG  (DONE_REG),
                .PASS_REG  (PASS_REG),
                .TNUM_REG  (TNUM_REG),
                .DRAIN_CYC (DRAIN_CYC)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .we          (wb_we_i[gi]),
                .addr        (wb_addr_i[REG_IDX_W*gi +: REG_IDX_W]),
                .data        (wb_data_i[XLEN*gi +: XLEN]),
                .judged_next (judged_next[gi]),
                .pass_next   (pass_vec[gi]),
                .tnum_next   (tnum_next[gi])
            );
            // A channel still unjudged when the timeout fires counts as failed.
            assign ch_pass_next[gi] = judged_next[gi] & pass_vec[gi];
        end
    endgenerate

    assign all_judged = &judged_next;
    assign tmo_hit    = (TIMEOUT != 0) && (cycles_reg == TMO_LAST) && !all_judged;
    assign fire       = !done_reg && (all_judged || tmo_hit);

    // Walk downwards so the lowest-index failing channel has the last word.
    always_comb begin
        fail_tnum_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!ch_pass_next[i]) begin
                fail_tnum_sel = tnum_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_reg      <= 1'b0;
            pass_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            ch_pass_reg   <= '0;
            fail_tnum_reg <= '0;
            cycles_reg    <= '0;
        end else begin
            if (!done_reg && cycles_reg != '1) begin
                cycles_reg <= cycles_reg + CNT_W'(1);
            end
            if (fire) begin
                done_reg      <= 1'b1;
                timeout_reg   <= tmo_hit;
                ch_pass_reg   <= ch_pass_next;
                pass_reg      <= !tmo_hit && (&ch_pass_next);
                fail_reg      <= tmo_hit || !(&ch_pass_next);
                fail_tnum_reg <= fail_tnum_sel;
            end
        end
    end

    assign done_o         = done_reg;
    assign pass_o         = pass_reg;
    assign fail_o         = fail_reg;
    assign timeout_o      = timeout_reg;
    assign ch_pass_o      = ch_pass_reg;
    assign fail_testnum_o = fail_tnum_reg;
    assign cycles_o       = cycles_reg;

`ifdef TEST_MON_TRACE_EN
    logic [NUM_CH-1:0] trace_judged_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            trace_judged_reg <= '0;
        end else begin
            trace_judged_reg <= judged_next;
            for (int i = 0; i < NUM_CH; i++) begin
                if (judged_next[i] && !trace_judged_reg[i]) begin
                    $display("ch%0d judged pass=%0d tnum=%0d", i, pass_vec[i], tnum_next[i]);
                end
            end
            if (fire) begin
                if (tmo_hit)
                    $display("rv_test_monitor: TIMEOUT testnum=%0d cycles=%0d", fail_tnum_sel, cycles_reg + CNT_W'(1));
                else if (&ch_pass_next)
                    $display("rv_test_monitor: PASS cycles=%0d", cycles_reg + CNT_W'(1));
                else
                    $display("rv_test_monitor: FAIL testnum=%0d cycles=%0d", fail_tnum_sel, cycles_reg + CNT_W'(1));
            end
        end
    end
`endif

endmodule
